// File: rtl/pipe_pkg.sv
// Shared types and payload layout for the EXE->MEM pipeline register.
// Single-bit control flags sit at the bottom of the flattened payload; wide fields are stacked above.
package pipe_pkg;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_e;

    localparam int OFF_LWSRC     = 0;
    localparam int OFF_MOVSRC    = 1;
    localparam int OFF_REG_WRITE = 2;
    localparam int OFF_DM_READ   = 3;
    localparam int OFF_DM_WRITE  = 4;
    localparam int FLAG_W        = 5;

    localparam logic LW_ALU_SRC = 1'b0;
    localparam logic MV_ALU_SRC = 1'b0;

    function automatic int payload_width(input int data_w, input int raddr_w);
        return FLAG_W + raddr_w + 3 * data_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: in_ready comes only from registered state, so no
// combinational path runs from out_ready back to in_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         issue;

    assign in_ready  = (state != SK_TWO);
    assign out_valid = (state != SK_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    // Payload registers only load on the transitions that move an entry; flush keeps stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SK_EMPTY;
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else if (flush) begin
            state <= SK_EMPTY;
        end else begin
            case (state)
                SK_EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= SK_ONE;
                    end
                end
                SK_ONE: begin
                    if (accept && issue) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= SK_TWO;
                    end else if (issue) begin
                        state <= SK_EMPTY;
                    end
                end
                SK_TWO: begin
                    if (issue) begin
                        main_q <= skid_q;
                        state  <= SK_ONE;
                    end
                end
                default: state <= SK_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register built on a 2-entry skid buffer, with valid-qualified
// side-effect strobes and a saturating stall-cycle counter.
module exe_mem_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               exe_valid,
    output logic               exe_ready,
    input  logic [DATA_W-1:0]  exe_sw_o,
    input  logic [DATA_W-1:0]  exe_write_o,
    input  logic [DATA_W-1:0]  exe_alu_result,
    input  logic [RADDR_W-1:0] exe_write_addr_o,
    input  logic               exe_lwsrc,
    input  logic               exe_movsrc,
    input  logic               exe_reg_write,
    input  logic               exe_DM_read,
    input  logic               exe_DM_write,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [DATA_W-1:0]  mem_sw_o,
    output logic [DATA_W-1:0]  mem_write_o,
    output logic [DATA_W-1:0]  mem_alu_result,
    output logic [RADDR_W-1:0] mem_write_addr_o,
    output logic               mem_lwsrc,
    output logic               mem_movsrc,
    output logic               mem_reg_write,
    output logic               mem_DM_read,
    output logic               mem_DM_write,
    output logic [CNT_W-1:0]   stall_cnt,
    input  logic               stall_clr
);

    localparam int OFF_WADDR = FLAG_W;
    localparam int OFF_ALU   = OFF_WADDR + RADDR_W;
    localparam int OFF_WRITE = OFF_ALU + DATA_W;
    localparam int OFF_SW    = OFF_WRITE + DATA_W;
    localparam int PAY_W     = payload_width(DATA_W, RADDR_W);

    localparam logic [PAY_W-1:0] PAY_RST = (PAY_W'(LW_ALU_SRC) << OFF_LWSRC)
                                         | (PAY_W'(MV_ALU_SRC) << OFF_MOVSRC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay;

    assign in_pay = {exe_sw_o, exe_write_o, exe_alu_result, exe_write_addr_o,
                     exe_DM_write, exe_DM_read, exe_reg_write, exe_movsrc, exe_lwsrc};

    pipe_skid_buf #(
        .W       (PAY_W),
        .RST_VAL (PAY_RST)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (exe_valid),
        .in_ready  (exe_ready),
        .in_data   (in_pay),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (out_pay)
    );

    assign mem_sw_o         = out_pay[OFF_SW +: DATA_W];
    assign mem_write_o      = out_pay[OFF_WRITE +: DATA_W];
    assign mem_alu_result   = out_pay[OFF_ALU +: DATA_W];
    assign mem_write_addr_o = out_pay[OFF_WADDR +: RADDR_W];
    assign mem_lwsrc        = out_pay[OFF_LWSRC];
    assign mem_movsrc       = out_pay[OFF_MOVSRC];
    // Stored strobe bits persist after issue, so gating by valid keeps bubbles inert.
    assign mem_reg_write    = out_pay[OFF_REG_WRITE] & mem_valid;
    assign mem_DM_read      = out_pay[OFF_DM_READ] & mem_valid;
    assign mem_DM_write     = out_pay[OFF_DM_WRITE] & mem_valid;

    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_cnt <= '0;
        end else if (mem_valid && !mem_ready && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Scoreboard bench for exe_mem_skid_reg: stimulus queues expected entries, a negedge
// monitor pops and compares them whenever the DUT issues.
module tb_exe_mem_skid_reg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               exe_valid;
    logic               exe_ready;
    logic [DATA_W-1:0]  exe_sw_o;
    logic [DATA_W-1:0]  exe_write_o;
    logic [DATA_W-1:0]  exe_alu_result;
    logic [RADDR_W-1:0] exe_write_addr_o;
    logic               exe_lwsrc;
    logic               exe_movsrc;
    logic               exe_reg_write;
    logic               exe_DM_read;
    logic               exe_DM_write;
    logic               mem_valid;
    logic               mem_ready;
    logic [DATA_W-1:0]  mem_sw_o;
    logic [DATA_W-1:0]  mem_write_o;
    logic [DATA_W-1:0]  mem_alu_result;
    logic [RADDR_W-1:0] mem_write_addr_o;
    logic               mem_lwsrc;
    logic               mem_movsrc;
    logic               mem_reg_write;
    logic               mem_DM_read;
    logic               mem_DM_write;
    logic [CNT_W-1:0]   stall_cnt;
    logic               stall_clr;

    typedef struct packed {
        logic [31:0] sw;
        logic [31:0] wr;
        logic [31:0] alu;
        logic [4:0]  waddr;
        logic        dw;
        logic        dr;
        logic        rw;
        logic        mv;
        logic        lw;
    } entry_t;

    entry_t sb[$];
    entry_t mon_exp;
    int     n_checks = 0;
    int     n_fails  = 0;

    exe_mem_skid_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .exe_valid        (exe_valid),
        .exe_ready        (exe_ready),
        .exe_sw_o         (exe_sw_o),
        .exe_write_o      (exe_write_o),
        .exe_alu_result   (exe_alu_result),
        .exe_write_addr_o (exe_write_addr_o),
        .exe_lwsrc        (exe_lwsrc),
        .exe_movsrc       (exe_movsrc),
        .exe_reg_write    (exe_reg_write),
        .exe_DM_read      (exe_DM_read),
        .exe_DM_write     (exe_DM_write),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_sw_o         (mem_sw_o),
        .mem_write_o      (mem_write_o),
        .mem_alu_result   (mem_alu_result),
        .mem_write_addr_o (mem_write_addr_o),
        .mem_lwsrc        (mem_lwsrc),
        .mem_movsrc       (mem_movsrc),
        .mem_reg_write    (mem_reg_write),
        .mem_DM_read      (mem_DM_read),
        .mem_DM_write     (mem_DM_write),
        .stall_cnt        (stall_cnt),
        .stall_clr        (stall_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic entry_t mk(input logic [31:0] alu, input logic [4:0] flags);
        entry_t e;
        e.alu   = alu;
        e.sw    = alu ^ 32'hA5A5_0000;
        e.wr    = alu + 32'h0000_0100;
        e.waddr = alu[4:0] ^ 5'h1F;
        {e.dw, e.dr, e.rw, e.mv, e.lw} = flags;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one entry for one cycle; push to the scoreboard when it should be accepted.
    task automatic applyStimulus(input entry_t e, input logic exp_ready, input logic push);
        exe_valid        = 1'b1;
        exe_sw_o         = e.sw;
        exe_write_o      = e.wr;
        exe_alu_result   = e.alu;
        exe_write_addr_o = e.waddr;
        {exe_DM_write, exe_DM_read, exe_reg_write, exe_movsrc, exe_lwsrc} = {e.dw, e.dr, e.rw, e.mv, e.lw};
        if (push) sb.push_back(e);
        @(negedge clk);
        checkOutput("exe_ready", {31'd0, exe_ready}, {31'd0, exp_ready});
        @(posedge clk);
        #1;
        exe_valid = 1'b0;
    endtask

    task automatic checkReset();
        checkOutput("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("rst_exe_ready", {31'd0, exe_ready}, 32'd1);
        checkOutput("rst_dm_write", {31'd0, mem_DM_write}, 32'd0);
        checkOutput("rst_reg_write", {31'd0, mem_reg_write}, 32'd0);
        checkOutput("rst_lwsrc", {31'd0, mem_lwsrc}, 32'd0);
        checkOutput("rst_movsrc", {31'd0, mem_movsrc}, 32'd0);
        checkOutput("rst_alu", mem_alu_result, 32'd0);
        checkOutput("rst_sw", mem_sw_o, 32'd0);
        checkOutput("rst_waddr", {27'd0, mem_write_addr_o}, 32'd0);
        checkOutput("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_issue: got alu 0x%0h, expected no entry at %0t", mem_alu_result, $time);
                end else begin
                    mon_exp = sb.pop_front();
                    checkOutput("mem_alu_result", mem_alu_result, mon_exp.alu);
                    checkOutput("mem_sw_o", mem_sw_o, mon_exp.sw);
                    checkOutput("mem_write_o", mem_write_o, mon_exp.wr);
                    checkOutput("mem_write_addr_o", {27'd0, mem_write_addr_o}, {27'd0, mon_exp.waddr});
                    checkOutput("mem_flags",
                                {27'd0, mem_DM_write, mem_DM_read, mem_reg_write, mem_movsrc, mem_lwsrc},
                                {27'd0, mon_exp.dw, mon_exp.dr, mon_exp.rw, mon_exp.mv, mon_exp.lw});
                end
            end else if (!mem_valid) begin
                checkOutput("bubble_strobes", {29'd0, mem_reg_write, mem_DM_read, mem_DM_write}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        flush            = 1'b0;
        exe_valid        = 1'b0;
        mem_ready        = 1'b0;
        stall_clr        = 1'b0;
        exe_sw_o         = '0;
        exe_write_o      = '0;
        exe_alu_result   = '0;
        exe_write_addr_o = '0;
        {exe_DM_write, exe_DM_read, exe_reg_write, exe_movsrc, exe_lwsrc} = 5'b0;

        tick(2);
        rst = 1'b0;
        checkReset();

        $display("[TB] back-to-back flow, 1-cycle latency");
        mem_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(mk(i, 5'b00100), 1'b1, 1'b1);
            checkOutput("latency_valid", {31'd0, mem_valid}, 32'd1);
            checkOutput("latency_alu", mem_alu_result, i);
        end
        tick(1);
        checkOutput("drained_valid", {31'd0, mem_valid}, 32'd0);

        $display("[TB] stall fills skid, release drains in order");
        mem_ready = 1'b0;
        applyStimulus(mk(32'h10, 5'b10100), 1'b1, 1'b1);
        applyStimulus(mk(32'h20, 5'b01101), 1'b1, 1'b1);
        applyStimulus(mk(32'h30, 5'b00110), 1'b0, 1'b0);
        checkOutput("hold_alu", mem_alu_result, 32'h10);
        mem_ready = 1'b1;
        applyStimulus(mk(32'h30, 5'b00110), 1'b0, 1'b0);
        applyStimulus(mk(32'h30, 5'b00110), 1'b1, 1'b1);
        tick(2);
        checkOutput("stall_cnt_after_release", {28'd0, stall_cnt}, 32'd2);
        checkOutput("release_empty", {31'd0, mem_valid}, 32'd0);

        $display("[TB] flush from TWO and from ONE with concurrent input");
        mem_ready = 1'b0;
        applyStimulus(mk(32'h40, 5'b00100), 1'b1, 1'b1);
        applyStimulus(mk(32'h41, 5'b10100), 1'b1, 1'b1);
        flush = 1'b1;
        sb.delete();
        applyStimulus(mk(32'h42, 5'b11100), 1'b0, 1'b0);
        flush = 1'b0;
        checkOutput("flush_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("flush_reg_write", {31'd0, mem_reg_write}, 32'd0);
        checkOutput("flush_exe_ready", {31'd0, exe_ready}, 32'd1);
        checkOutput("flush_no_stall_inc", {28'd0, stall_cnt}, 32'd3);
        applyStimulus(mk(32'h43, 5'b00100), 1'b1, 1'b1);
        flush = 1'b1;
        sb.delete();
        applyStimulus(mk(32'h44, 5'b11100), 1'b1, 1'b0);
        flush = 1'b0;
        checkOutput("flush_one_valid", {31'd0, mem_valid}, 32'd0);
        mem_ready = 1'b1;
        tick(3);
        checkOutput("flush_nothing_out", {31'd0, mem_valid}, 32'd0);

        $display("[TB] stall counter saturation and clear");
        mem_ready = 1'b0;
        stall_clr = 1'b1;
        applyStimulus(mk(32'h50, 5'b00001), 1'b1, 1'b1);
        stall_clr = 1'b0;
        tick(14);
        checkOutput("stall_cnt_14", {28'd0, stall_cnt}, 32'd14);
        tick(6);
        checkOutput("stall_cnt_sat", {28'd0, stall_cnt}, 32'd15);
        stall_clr = 1'b1;
        tick(1);
        stall_clr = 1'b0;
        checkOutput("stall_clr_wins", {28'd0, stall_cnt}, 32'd0);
        tick(1);
        checkOutput("stall_cnt_resume", {28'd0, stall_cnt}, 32'd1);
        mem_ready = 1'b1;
        tick(1);
        checkOutput("sat_drained", {31'd0, mem_valid}, 32'd0);

        $display("[TB] DM_write strobe for a single issue cycle");
        applyStimulus(mk(32'h60, 5'b10000), 1'b1, 1'b1);
        checkOutput("dm_write_high", {31'd0, mem_DM_write}, 32'd1);
        tick(1);
        checkOutput("dm_write_bubble", {31'd0, mem_DM_write}, 32'd0);
        checkOutput("dm_write_bubble_valid", {31'd0, mem_valid}, 32'd0);

        $display("[TB] reset from TWO");
        mem_ready = 1'b0;
        applyStimulus(mk(32'h70, 5'b11111), 1'b1, 1'b1);
        applyStimulus(mk(32'h71, 5'b11111), 1'b1, 1'b1);
        rst = 1'b1;
        sb.delete();
        tick(2);
        rst = 1'b0;
        checkReset();

        mem_ready = 1'b1;
        tick(3);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
